// File: rtl/character_mover.sv
// character_mover: tick-paced platformer sprite mover with tile-map collision.
// Optional feature macro CHARACTER_MOVER_VAR_JUMP_EN: releasing jump mid-rise ends the rise early.
module character_mover #(
    parameter int TICK_DIV        = 833333,
    parameter int H_STEP          = 2,
    parameter int JUMP_STEP       = 3,
    parameter int FALL_STEP       = 3,
    parameter int JUMP_TICKS      = 40,
    parameter int START_X         = 40,
    parameter int START_Y         = 398,
    parameter int CHARACTER_WIDTH = 42,
    parameter int BLOCK_WIDTH     = 40,
    parameter int SCREEN_WIDTH    = 640,
    parameter int SCREEN_HEIGHT   = 480,
    parameter int BDR             = 0,
    parameter int SKY             = 1,
    parameter int BLK             = 2,
    parameter int GND             = 3,
    parameter int TKN             = 4,
    parameter int CK1             = 5,
    parameter int CK2             = 6
) (
    input  logic vga_clock,
    input  logic reset,
    input  logic left,
    input  logic right,
    input  logic jump,
    input  byte  background [11:0][16:0],
    output int   mario_x,
    output int   mario_y,
    output logic facing_left,
    output logic airborne,
    output logic tick
);

    localparam int TICK_W = $clog2(TICK_DIV);
    localparam int RISE_W = $clog2(JUMP_TICKS + 1);
    localparam int X_MAX  = SCREEN_WIDTH - CHARACTER_WIDTH;
    localparam int Y_MAX  = SCREEN_HEIGHT - CHARACTER_WIDTH;
    localparam int EDGE   = CHARACTER_WIDTH - 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [TICK_W-1:0] TICK_PRE  = TICK_W'(TICK_DIV - 2);
    localparam logic [RISE_W-1:0] RISE_ZERO = {RISE_W{1'b0}};

    typedef enum logic [1:0] {
        GROUNDED = 2'd0,
        RISING   = 2'd1,
        FALLING  = 2'd2
    } state_t;

    logic [TICK_W-1:0] tick_cnt_r;
    logic              tick_r;
    int                x_r, y_r;
    logic              facing_r, airborne_r, jump_prev_r;
    state_t            state_r, state_next_s;
    logic [RISE_W-1:0] rise_cnt_r, rise_next_s, rise_dec_s;
    int                x_next_s, x_cand_s, x_lead_s;
    int                y_next_s, y_cand_s, y_foot_s;
    logic              facing_next_s, rise_release_s;

    function automatic logic solid_code(input byte code);
        logic res;
        case (int'(code))
            BDR, BLK, GND:      res = 1'b1;
            SKY, TKN, CK1, CK2: res = 1'b0;
            default:            res = 1'b0;
        endcase
        return res;
    endfunction

    // Off-map lookups (including negative coordinates) read as solid.
    function automatic logic solid_at(input int px, input int py);
        int   col;
        int   row;
        logic res;
        col = px / BLOCK_WIDTH;
        row = py / BLOCK_WIDTH;
        if (px < 32'sd0 || py < 32'sd0 || col > 32'sd16 || row > 32'sd11) begin
            res = 1'b1;
        end else begin
            res = solid_code(background[row[3:0]][col[4:0]]);
        end
        return res;
    endfunction

    function automatic int clamp_int(input int v, input int lo, input int hi);
        int res;
        if (v < lo)      res = lo;
        else if (v > hi) res = hi;
        else             res = v;
        return res;
    endfunction

`ifdef CHARACTER_MOVER_VAR_JUMP_EN
    assign rise_release_s = ~jump;
`else
    assign rise_release_s = 1'b0;
`endif

    // Free-running tick divider; tick is high while the counter sits at TICK_DIV-1.
    always_ff @(posedge vga_clock) begin
        if (reset) begin
            tick_cnt_r <= {TICK_W{1'b0}};
            tick_r     <= 1'b0;
        end else begin
            tick_cnt_r <= (tick_cnt_r == TICK_LAST) ? {TICK_W{1'b0}} : tick_cnt_r + TICK_W'(1);
            tick_r     <= (tick_cnt_r == TICK_PRE);
        end
    end

    // Horizontal candidate: step, clamp to screen, then snap flush against a wall.
    always_comb begin
        x_next_s      = x_r;
        facing_next_s = facing_r;
        x_cand_s      = x_r;
        x_lead_s      = x_r;
        if (left && !right) begin
            facing_next_s = 1'b1;
            x_cand_s      = clamp_int(x_r - H_STEP, 32'sd0, X_MAX);
            x_lead_s      = x_cand_s;
            if (solid_at(x_lead_s, y_r) || solid_at(x_lead_s, y_r + EDGE)) begin
                x_next_s = (x_lead_s / BLOCK_WIDTH + 32'sd1) * BLOCK_WIDTH;
            end else begin
                x_next_s = x_cand_s;
            end
        end else if (right && !left) begin
            facing_next_s = 1'b0;
            x_cand_s      = clamp_int(x_r + H_STEP, 32'sd0, X_MAX);
            x_lead_s      = x_cand_s + EDGE;
            if (solid_at(x_lead_s, y_r) || solid_at(x_lead_s, y_r + EDGE)) begin
                x_next_s = (x_lead_s / BLOCK_WIDTH) * BLOCK_WIDTH - CHARACTER_WIDTH;
            end else begin
                x_next_s = x_cand_s;
            end
        end else begin
            x_next_s = x_r;
        end
    end

    // Vertical FSM: ground check beats jump; ceilings and floors snap to tile edges.
    always_comb begin
        state_next_s = state_r;
        y_next_s     = y_r;
        rise_next_s  = rise_cnt_r;
        y_cand_s     = y_r;
        y_foot_s     = y_r + EDGE;
        rise_dec_s   = rise_cnt_r - RISE_W'(1);
        case (state_r)
            GROUNDED: begin
                if (!solid_at(x_r, y_r + CHARACTER_WIDTH) ||
                    !solid_at(x_r + EDGE, y_r + CHARACTER_WIDTH)) begin
                    state_next_s = FALLING;
                end else if (jump && !jump_prev_r) begin
                    state_next_s = RISING;
                    rise_next_s  = RISE_W'(JUMP_TICKS);
                end else begin
                    state_next_s = GROUNDED;
                end
            end
            RISING: begin
                if (rise_release_s) begin
                    state_next_s = FALLING;
                    rise_next_s  = RISE_ZERO;
                end else begin
                    y_cand_s = clamp_int(y_r - JUMP_STEP, 32'sd0, Y_MAX);
                    if (solid_at(x_r, y_cand_s) || solid_at(x_r + EDGE, y_cand_s)) begin
                        y_next_s     = (y_cand_s / BLOCK_WIDTH + 32'sd1) * BLOCK_WIDTH;
                        state_next_s = FALLING;
                        rise_next_s  = RISE_ZERO;
                    end else begin
                        y_next_s    = y_cand_s;
                        rise_next_s = rise_dec_s;
                        if (rise_dec_s == RISE_ZERO || y_cand_s == 32'sd0) begin
                            state_next_s = FALLING;
                        end else begin
                            state_next_s = RISING;
                        end
                    end
                end
            end
            FALLING: begin
                y_cand_s = y_r + FALL_STEP;
                y_foot_s = y_cand_s + EDGE;
                if (solid_at(x_r, y_foot_s) || solid_at(x_r + EDGE, y_foot_s)) begin
                    y_next_s     = (y_foot_s / BLOCK_WIDTH) * BLOCK_WIDTH - CHARACTER_WIDTH;
                    state_next_s = GROUNDED;
                end else if (y_cand_s >= Y_MAX) begin
                    y_next_s     = Y_MAX;
                    state_next_s = GROUNDED;
                end else begin
                    y_next_s     = y_cand_s;
                    state_next_s = FALLING;
                end
            end
            default: begin
                state_next_s = GROUNDED;
                rise_next_s  = RISE_ZERO;
            end
        endcase
    end

    // Movement state commits only on the tick edge; jump history is sampled per tick.
    always_ff @(posedge vga_clock) begin
        if (reset) begin
            x_r         <= START_X;
            y_r         <= START_Y;
            facing_r    <= 1'b0;
            state_r     <= GROUNDED;
            airborne_r  <= 1'b0;
            rise_cnt_r  <= RISE_ZERO;
            jump_prev_r <= 1'b1;
        end else if (tick_r) begin
            x_r         <= x_next_s;
            y_r         <= y_next_s;
            facing_r    <= facing_next_s;
            state_r     <= state_next_s;
            airborne_r  <= (state_next_s != GROUNDED);
            rise_cnt_r  <= rise_next_s;
            jump_prev_r <= jump;
        end
    end

    assign mario_x     = x_r;
    assign mario_y     = y_r;
    assign facing_left = facing_r;
    assign airborne    = airborne_r;
    assign tick        = tick_r;

endmodule

// File: doc/character_mover.md
CHARACTER_MOVER -- requirements
Module: character_mover

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning:
- TICK_DIV, 833333, vga_clock cycles per movement tick (minimum 2).
- H_STEP, 2, horizontal pixels per tick.
- JUMP_STEP, 3, upward pixels per rising tick.
- FALL_STEP, 3, downward pixels per falling tick.
- JUMP_TICKS, 40, maximum rising ticks per jump.
- START_X, 40, reset x.
- START_Y, 398, reset y.
- CHARACTER_WIDTH, 42, sprite edge in pixels; the sprite is square.
- BLOCK_WIDTH, 40, tile edge in pixels.
- SCREEN_WIDTH, 640, screen width.
- SCREEN_HEIGHT, 480, screen height.
- BDR, 0, tile code.
- SKY, 1, tile code.
- BLK, 2, tile code.
- GND, 3, tile code.
- TKN, 4, tile code.
- CK1, 5, tile code.
- CK2, 6, tile code.

REQ-002 SHALL have ports, one per line: name direction width meaning:
- vga_clock input 1: the single clock.
- reset input 1: synchronous, active-high.
- left input 1: move left, active-high.
- right input 1: move right, active-high.
- jump input 1: jump request, active-high.
- background input byte[11:0][16:0]: tile map indexed [row][col].
- mario_x output int: sprite left edge.
- mario_y output int: sprite top edge.
- facing_left output 1: last horizontal direction.
- airborne output 1: state is not GROUNDED.
- tick output 1: one-cycle movement-tick strobe.

Function
REQ-003 SHALL run a free counter from 0 to TICK_DIV-1 and pulse tick high in the cycle the counter equals TICK_DIV-1; all position and state updates SHALL occur only on that edge, and outputs SHALL be registered and visible the following cycle.
REQ-004 SHALL treat a tile as solid when its code is BDR, BLK or GND; all other codes are passable. Tile lookup uses col = px/BLOCK_WIDTH and row = py/BLOCK_WIDTH. Any lookup with col>16 or row>11 SHALL read as solid.
REQ-005 SHALL compute horizontal and vertical candidates from the same pre-tick mario_x and mario_y; both results SHALL commit on the same tick.
REQ-006 Horizontal rule:
- left only gives x-H_STEP; right only gives x+H_STEP.
- Both or neither gives no move, and facing_left is unchanged.
- Candidate SHALL be clamped to [0, SCREEN_WIDTH-CHARACTER_WIDTH].
- If the leading-edge column at the top row or the bottom row (y, y+CHARACTER_WIDTH-1) is solid, x SHALL snap flush to that tile's edge.
REQ-007 facing_left SHALL be set to 1 on a left-only tick and cleared to 0 on a right-only tick.
REQ-008 SHALL implement the FSM GROUNDED, RISING, FALLING, held in a 2-bit state register, with a rise counter sized for JUMP_TICKS.
REQ-009 GROUNDED transitions:
- If the row at y+CHARACTER_WIDTH under either x or x+CHARACTER_WIDTH-1 is not solid, go to FALLING.
- Otherwise, on a jump rising edge, go to RISING and load the counter with JUMP_TICKS.
- The falling-edge check SHALL take priority over the jump.
REQ-010 Jump edge SHALL be detected as jump=1 at this tick and jump=0 at the previous tick (sampled per tick, not per clock). Holding jump SHALL NOT re-trigger after landing.
REQ-011 RISING:
- y SHALL become max(y-JUMP_STEP, 0) and the counter SHALL decrement.
- A solid tile above either top corner SHALL snap y to the tile's bottom edge and go to FALLING.
- Counter reaching 0 or y reaching 0 SHALL also go to FALLING.
REQ-012 FALLING:
- y SHALL become y+FALL_STEP.
- A solid tile under either bottom corner SHALL snap y to tile_top-CHARACTER_WIDTH and go to GROUNDED.
- y SHALL clamp at SCREEN_HEIGHT-CHARACTER_WIDTH, which also goes to GROUNDED.
REQ-013 airborne SHALL equal (state != GROUNDED), registered.
REQ-014 Arithmetic SHALL be signed 32-bit; negative candidates SHALL be clamped before tile lookup.

Reset
REQ-015 On reset=1 at a vga_clock edge:
- mario_x=START_X, mario_y=START_Y.
- facing_left=0, state=GROUNDED, airborne=0.
- tick counter=0, tick=0, rise counter=0.
- Previous-jump sample=1, so a held jump at release does not fire.
REQ-016 Reset mid-jump or mid-fall SHALL take effect on that edge, with no residual motion on the next tick.

Configuration
REQ-017 Macro CHARACTER_MOVER_VAR_JUMP_EN:
- When defined, jump=0 sampled on a RISING tick SHALL end the rise: FALLING begins that tick, with no upward step.
- When undefined, the rise SHALL always run the full JUMP_TICKS unless blocked by a ceiling, regardless of jump.

Verification
All scenarios use TICK_DIV=4, an empty sky map with ground row 11, START_Y=398 and defaults otherwise.
REQ-018 Hold right for 10 ticks from x=40 -> mario_x=60, facing_left=0, airborne=0, and tick high once every 4 cycles.
REQ-019 Pulse jump for one tick, macro undefined -> 40 rising ticks, then apex y=278, then falling ticks until y=398 and airborne=0. Holding jump afterwards -> no second jump.
REQ-020 Place a BLK at row 9 col 2, then hold right from x=30 -> x snaps to 38 and stays at 38.
REQ-021 Set the ground tile under the sprite to SKY -> on the next tick airborne=1, then y increases by 3 per tick until it clamps at 438.
REQ-022 With the macro defined, release jump after 5 rising ticks -> rise ends at y=383, and falling starts that tick.
REQ-023 Assert reset during RISING -> next cycle mario_x=40, mario_y=398, airborne=0, and no motion on the following tick.
